// File: rtl/cim_requant_unit.sv
// Requantizes signed MAC accumulators to int8: bias, scale, rounding shift,
// optional ReLU, saturation, then an output FIFO with credit-based admission.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   acc_in/acc_valid    signed accumulator and its one-cycle strobe
//   acc_ready           a FIFO slot is guaranteed for a result taken now
//   cfg_bias/scale/     per-result config, captured with the accumulator
//   cfg_shift/cfg_relu
//   out_data/out_valid  FIFO head toward writeback; popped on out_ready
//   out_ready
//   sat_count           results clipped by saturation, sticks at 0xFFFF
//   overflow_err        sticky: a result arrived while acc_ready was low
module cim_requant_unit #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [ACC_WIDTH-1:0]   cfg_bias,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   cfg_relu,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            sat_count,
  output logic                   overflow_err
);

  localparam int S1W = ACC_WIDTH + 1;
  localparam int PW  = ACC_WIDTH + SCALE_WIDTH + 2;
  localparam int RW  = PW + 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;

  localparam logic signed [RW-1:0] OMAX =
    RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  // stage 1: bias already added at capture
  logic                   v1;
  logic signed [S1W-1:0]  s1;
  logic [SCALE_WIDTH-1:0] scale1;
  logic [SHIFT_WIDTH-1:0] shift1;
  logic                   relu1;

  // stage 2: scaled product
  logic                   v2;
  logic signed [PW-1:0]   s2;
  logic [SHIFT_WIDTH-1:0] shift2;
  logic                   relu2;

  // stage 3 is combinational and lands in the FIFO on the same edge
  logic signed [RW-1:0]   rnd;
  logic signed [RW-1:0]   rsum;
  logic signed [RW-1:0]   rq;
  logic signed [RW-1:0]   rr;
  logic [OUT_WIDTH-1:0]   res;
  logic                   sat;

  logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [CW-1:0]          count;
  logic [CW:0]            credit;
  logic                   accept;
  logic                   push;
  logic                   pop;

  // every result in flight already owns a slot, so no stall is needed
  assign credit    = {1'b0, count} + (CW+1)'(v1) + (CW+1)'(v2);
  assign acc_ready = credit < (CW+1)'(FIFO_DEPTH);
  assign accept    = acc_valid & acc_ready;

  assign out_valid = count != '0;
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign push      = v2;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1     <= S1W'($signed(acc_in)) + S1W'($signed(cfg_bias));
      scale1 <= cfg_scale;
      shift1 <= cfg_shift;
      relu1  <= cfg_relu;
    end
    s2     <= PW'(s1) * PW'($signed({1'b0, scale1}));
    shift2 <= shift1;
    relu2  <= relu1;
  end

  always_comb begin
    rnd = '0;
    if (shift2 != '0) begin
      rnd = RW'(1) << (shift2 - SHIFT_WIDTH'(1));
    end
    rsum = RW'(s2) + rnd;
    rq   = rsum >>> shift2;
    rr   = (relu2 && rq < 0) ? '0 : rq;
    res  = rr[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (rr > OMAX) begin
      res = OMAX[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (rr < OMIN) begin
      res = OMIN[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count    <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push && sat && sat_count != 16'hFFFF) begin
        sat_count <= sat_count + 16'd1;
      end
      if (acc_valid && !acc_ready) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cim_requant_unit.sv
// Bench for cim_requant_unit: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_cim_requant_unit;

  logic        clk;
  logic        rst;
  logic [31:0] acc_in;
  logic        acc_valid;
  logic        acc_ready;
  logic [31:0] cfg_bias;
  logic [15:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sat_count;
  logic        overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  cim_requant_unit dut (
    .clk(clk), .rst(rst),
    .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .cfg_bias(cfg_bias), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_count(sat_count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // Reference arithmetic straight from the requantization rules.
  function automatic void model(input int acc, input int bias,
                                input int scale, input int shift,
                                input bit relu,
                                output int r, output bit sat);
    longint t;
    t = (longint'(acc) + longint'(bias)) * longint'(scale);
    if (shift > 0) t = t + (longint'(1) << (shift - 1));
    t = t >>> shift;
    if (relu && t < 0) t = 0;
    sat = 1'b0;
    if (t > 127) begin
      r = 127; sat = 1'b1;
    end else if (t < -128) begin
      r = -128; sat = 1'b1;
    end else begin
      r = int'(t);
    end
  endfunction

  // Outstanding results: in flight or queued, oldest first, each
  // visible at the output from cycle rdy on.
  typedef struct {
    int     val;
    longint rdy;
    bit     sat;
  } ent_t;

  ent_t   q[$];
  longint cyc = 0;
  int     m_sat = 0;
  bit     m_ovf = 1'b0;

  always @(negedge clk) begin
    bit ev;
    int ed;
    bit er;
    int r;
    bit s;
    if (rst) begin
      q.delete();
      m_sat = 0;
      m_ovf = 1'b0;
    end else begin
      foreach (q[i]) begin
        if (q[i].rdy == cyc && q[i].sat && m_sat != 65535) m_sat++;
      end
      ev = q.size() > 0 && q[0].rdy <= cyc;
      ed = ev ? q[0].val : 0;
      er = q.size() < 8;
      chk("m_out_valid", out_valid, ev);
      chk("m_out_data", $signed(out_data), ed);
      chk("m_acc_ready", acc_ready, er);
      chk("m_sat_count", sat_count, m_sat);
      chk("m_overflow_err", overflow_err, m_ovf);
      if (ev && out_ready) void'(q.pop_front());
      if (acc_valid) begin
        if (er) begin
          model($signed(acc_in), $signed(cfg_bias), int'(cfg_scale),
                int'(cfg_shift), cfg_relu, r, s);
          q.push_back('{val: r, rdy: cyc + 3, sat: s});
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    cyc++;
  end

  task automatic step(input bit v, input int a, input int b,
                      input int sc, input int sh, input bit rl);
    @(posedge clk);
    #1;
    acc_valid = v;
    acc_in    = a;
    cfg_bias  = b;
    cfg_scale = 16'(sc);
    cfg_shift = 5'(sh);
    cfg_relu  = rl;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
    end
  endtask

  task automatic one(input string nm, input int a, input int b,
                     input int sc, input int sh, input bit rl,
                     input int exp);
    step(1'b1, a, b, sc, sh, rl);
    idle(3);
    chk({nm, "_valid"}, out_valid, 1);
    chk(nm, $signed(out_data), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    bit s;
    int got[$];

    rst = 1'b1;
    out_ready = 1'b1;
    acc_valid = 1'b0;
    acc_in = '0;
    cfg_bias = '0;
    cfg_scale = 16'd1;
    cfg_shift = '0;
    cfg_relu = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_acc_ready", acc_ready, 1);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_overflow", overflow_err, 0);

    model(100, 0, 1, 0, 0, r, s);    chk("pin_pass", r, 100);
    model(256, 0, 1, 0, 0, r, s);    chk("pin_sat_hi", r, 127);
    chk("pin_sat_hi_flag", s, 1);
    model(1240, 0, 1, 4, 0, r, s);   chk("pin_round", r, 78);
    model(10, -20, 3, 1, 0, r, s);   chk("pin_neg_round", r, -15);
    model(-400, 0, 1, 2, 1, r, s);   chk("pin_relu", r, 0);
    chk("pin_relu_flag", s, 0);

    one("pass_100", 100, 0, 1, 0, 0, 100);
    one("sat_256", 256, 0, 1, 0, 0, 127);
    chk("sat_cnt_1", sat_count, 1);
    one("round_1240", 1240, 0, 1, 4, 0, 78);
    one("round_neg", 10, -20, 3, 1, 0, -15);
    one("neg_400", -400, 0, 1, 2, 0, -100);
    one("relu_400", -400, 0, 1, 2, 1, 0);
    chk("relu_no_sat", sat_count, 1);
    one("sat_lo", -1000, 0, 1, 0, 0, -128);
    chk("sat_cnt_2", sat_count, 2);
    idle(2);

    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, k, 0, 1, 0, 0);
      if (k == 8) chk("bp_ready_at_8", acc_ready, 1);
      if (k == 9) chk("bp_ready_low", acc_ready, 0);
    end
    idle(1);
    chk("bp_overflow", overflow_err, 1);
    idle(3);
    chk("bp_full_valid", out_valid, 1);
    chk("bp_head", $signed(out_data), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) got.push_back(int'($signed(out_data)));
      idle(1);
    end
    chk("bp_drain_count", got.size(), 8);
    foreach (got[i]) chk("bp_drain_order", got[i], i + 1);
    chk("bp_empty", out_valid, 0);
    chk("bp_ready_back", acc_ready, 1);

    for (int i = 0; i < 20; i++) begin
      step(1'b1, i * 7 - 60, 5, 2, 1, 0);
      chk("stream_ready", acc_ready, 1);
    end
    idle(5);
    chk("stream_drained", out_valid, 0);

    out_ready = 1'b0;
    one("pre_rst_sat", 900, 0, 1, 0, 0, 127);
    for (int k = 11; k <= 15; k++) step(1'b1, k, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", acc_ready, 1);
    chk("mid_rst_sat", sat_count, 0);
    chk("mid_rst_ovf", overflow_err, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("mid_rst_no_stale", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
